picorv32_mem_arbiter: RTL and testbench

- Shares one single-ported memory between the picorv32 instruction and data request channels (req/gnt/addr/wdata/strb/we/rdata).
- Sits between the core memory wrapper and a unified SRAM/bus port.
- Allows one outstanding transaction at a time and routes the response back to the requester that issued it.
- Uses fixed priority with a starvation guard, so the low-priority side cannot be locked out.

---
 rtl/picorv32_mem_pkg.sv | 19 +
 rtl/picorv32_mem_arbiter_if.sv | 16 +
 rtl/picorv32_prio_sel.sv | 45 ++++
 rtl/picorv32_mem_arbiter.sv | 93 +++++++++
 tb/tb_picorv32_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/picorv32_mem_pkg.sv
// Shared types for the picorv32 instruction/data memory arbiter.
package picorv32_mem_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  strb_t;

  typedef struct packed {
    addr_t addr;
    data_t wdata;
    strb_t strb;
    logic  we;
  } mem_req_t;

  typedef enum logic {OWNER_INSTR, OWNER_DATA} owner_e;

  typedef enum logic {IDLE, WAIT_RSP} arb_state_e;

endpackage

// File: rtl/picorv32_mem_arbiter_if.sv
// One req/gnt/rvalid memory channel; the requester is the master, the memory side the slave.
interface picorv32_mem_arbiter_if;
  import picorv32_mem_pkg::*;

  logic  req;
  logic  gnt;
  addr_t addr;
  data_t wdata;
  strb_t strb;
  logic  we;
  logic  rvalid;
  data_t rdata;

  modport master (output req, addr, wdata, strb, we, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wdata, strb, we, output gnt, rvalid, rdata);
endinterface

// File: rtl/picorv32_prio_sel.sv
// Fixed-priority instr/data selection with a saturating starvation counter that
// hands one conflict to the low-priority side after STARVE_LIMIT consecutive losses.
module picorv32_prio_sel #(
  parameter int DATA_PRIO    = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic instr_req,
  input  logic data_req,
  input  logic fire,
  output logic sel_data
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic conflict, forced, low_won;

  assign conflict = instr_req && data_req;
  assign forced   = (cnt_q == LIMIT);

  always_comb begin
    sel_data = data_req;
    if (conflict) sel_data = (DATA_PRIO != 0) ? !forced : forced;
  end

  assign low_won = (DATA_PRIO != 0) ? !sel_data : sel_data;

  // Only a granted conflict lost by the low side counts; any low-side grant clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (fire) begin
      if (low_won)                cnt_d = '0;
      else if (conflict && !forced) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one single-ported memory between the picorv32 instruction and data channels,
// one outstanding transaction at a time, responses routed back to the issuing channel.
module picorv32_mem_arbiter
  import picorv32_mem_pkg::*;
#(
  parameter int DATA_PRIO    = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  picorv32_mem_arbiter_if.slave         instr_if,
  picorv32_mem_arbiter_if.slave         data_if,
  picorv32_mem_arbiter_if.master        mem_if,
  output logic                          busy
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       arb_en, sel_data, sel_valid, fire, rsp;
  logic       instr_rsp, data_rsp;
  mem_req_t   instr_r, data_r, sel_r;

  // A returning response frees the port in the same cycle, allowing back-to-back grants.
  assign arb_en    = (state_q == IDLE) || mem_if.rvalid;
  assign sel_valid = arb_en && (instr_if.req || data_if.req);
  assign fire      = sel_valid && mem_if.gnt;

  picorv32_prio_sel #(
    .DATA_PRIO   (DATA_PRIO),
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_sel (
    .clk      (clk),
    .rst      (rst),
    .instr_req(instr_if.req),
    .data_req (data_if.req),
    .fire     (fire),
    .sel_data (sel_data)
  );

  always_comb begin
    instr_r = '{addr: instr_if.addr, wdata: instr_if.wdata, strb: instr_if.strb, we: instr_if.we};
    data_r  = '{addr: data_if.addr, wdata: data_if.wdata, strb: data_if.strb, we: data_if.we};
    sel_r   = '0;
    if (sel_valid) sel_r = sel_data ? data_r : instr_r;
  end

  assign mem_if.req   = sel_valid;
  assign mem_if.addr  = sel_r.addr;
  assign mem_if.wdata = sel_r.wdata;
  assign mem_if.strb  = sel_r.strb;
  assign mem_if.we    = sel_r.we;

  assign instr_if.gnt = fire && !sel_data;
  assign data_if.gnt  = fire && sel_data;

  // A response is only meaningful while waiting; mem_rvalid in IDLE is dropped.
  assign rsp       = (state_q == WAIT_RSP) && mem_if.rvalid;
  assign instr_rsp = rsp && (owner_q == OWNER_INSTR);
  assign data_rsp  = rsp && (owner_q == OWNER_DATA);

  assign instr_if.rvalid = instr_rsp;
  assign instr_if.rdata  = instr_rsp ? mem_if.rdata : '0;
  assign data_if.rvalid  = data_rsp;
  assign data_if.rdata   = data_rsp ? mem_if.rdata : '0;

  assign busy = (state_q == WAIT_RSP);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (fire) begin
      state_d = WAIT_RSP;
      owner_d = sel_data ? OWNER_DATA : OWNER_INSTR;
    end else if (rsp) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_INSTR;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      assert (!(state_q == IDLE && mem_if.rvalid))
        else $info("picorv32_mem_arbiter: mem_rvalid with no outstanding request ignored");
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter with a response scoreboard.
module tb_picorv32_mem_arbiter;
  import picorv32_mem_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  picorv32_mem_arbiter_if instr_bus ();
  picorv32_mem_arbiter_if data_bus ();
  picorv32_mem_arbiter_if mem_bus ();

  picorv32_mem_arbiter #(.DATA_PRIO(1), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .instr_if(instr_bus),
    .data_if (data_bus),
    .mem_if  (mem_bus),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic push(input logic is_data, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    sb.push_back(e);
  endtask

  // Pops the oldest expected response and checks routing and data on both channels.
  task automatic rsp_check(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL %s_sb observed=empty expected=pending", tag);
      end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      $display("rsp %s chan=%s rdata=%h", tag, e.is_data ? "D" : "I", e.rdata);
      chk({tag, "_irv"}, 32'(instr_bus.rvalid), 32'(!e.is_data));
      chk({tag, "_drv"}, 32'(data_bus.rvalid), 32'(e.is_data));
      chk({tag, "_ird"}, instr_bus.rdata, e.is_data ? 32'h0 : e.rdata);
      chk({tag, "_drd"}, data_bus.rdata, e.is_data ? e.rdata : 32'h0);
    end
  endtask

  task automatic no_rsp(input string tag);
    chk({tag, "_irv0"}, 32'(instr_bus.rvalid), 32'h0);
    chk({tag, "_drv0"}, 32'(data_bus.rvalid), 32'h0);
    chk({tag, "_ird0"}, instr_bus.rdata, 32'h0);
    chk({tag, "_drd0"}, data_bus.rdata, 32'h0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    instr_bus.req = 0; instr_bus.addr = '0; instr_bus.wdata = '0; instr_bus.strb = '0; instr_bus.we = 0;
    data_bus.req  = 0; data_bus.addr  = '0; data_bus.wdata  = '0; data_bus.strb  = '0; data_bus.we  = 0;
    mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("reset state");
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mreq", 32'(mem_bus.req), 32'h0);
    chk("rst_maddr", mem_bus.addr, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_cnt", 32'(dut.u_sel.cnt_q), 32'h0);
    no_rsp("rst");

    // Single data read.
    nxt();
    data_bus.req = 1; data_bus.addr = 32'h8000_0100; mem_bus.gnt = 1;
    @(negedge clk);
    $display("data read addr=80000100");
    chk("dr_dgnt", 32'(data_bus.gnt), 32'h1);
    chk("dr_ignt", 32'(instr_bus.gnt), 32'h0);
    chk("dr_maddr", mem_bus.addr, 32'h8000_0100);
    no_rsp("dr_c0");
    push(1'b1, 32'hDEAD_BEEF);
    nxt();
    data_bus.req = 0; mem_bus.gnt = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("dr_busy", 32'(busy), 32'h1);
    rsp_check("dr");
    nxt();
    mem_bus.rvalid = 0;
    @(negedge clk);
    chk("dr_idle", 32'(busy), 32'h0);

    // Continuous conflict: expect D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++) begin
      nxt();
      instr_bus.req = 1; instr_bus.addr = 32'h8000_1000 + 32'(4 * k);
      data_bus.req = 1; data_bus.addr = 32'h9000_0000 + 32'(4 * k);
      mem_bus.gnt = 1; mem_bus.rvalid = (k > 0); mem_bus.rdata = 32'hC000_0000 + 32'(k);
      @(negedge clk);
      if (k > 0) rsp_check($sformatf("cf%0d", k));
      exp_d = (k % 5) != 4;
      $display("conflict cycle %0d expect grant %s", k, exp_d ? "D" : "I");
      chk($sformatf("cf%0d_cnt", k), 32'(dut.u_sel.cnt_q), 32'(k % 5));
      chk($sformatf("cf%0d_dgnt", k), 32'(data_bus.gnt), 32'(exp_d));
      chk($sformatf("cf%0d_ignt", k), 32'(instr_bus.gnt), 32'(!exp_d));
      chk($sformatf("cf%0d_maddr", k), mem_bus.addr,
          exp_d ? 32'h9000_0000 + 32'(4 * k) : 32'h8000_1000 + 32'(4 * k));
      push(exp_d, 32'hC000_0000 + 32'(k + 1));
    end
    nxt();
    instr_bus.req = 0; data_bus.req = 0; mem_bus.gnt = 0;
    mem_bus.rvalid = 1; mem_bus.rdata = 32'hC000_000A;
    @(negedge clk);
    rsp_check("cf10");
    chk("cf_cnt_end", 32'(dut.u_sel.cnt_q), 32'h0);
    nxt();
    mem_bus.rvalid = 0;
    @(negedge clk);
    chk("cf_idle", 32'(busy), 32'h0);

    // Back-to-back instruction fetches.
    nxt();
    instr_bus.req = 1; instr_bus.addr = 32'h8000_0000; mem_bus.gnt = 1;
    @(negedge clk);
    $display("fetch addr=80000000");
    chk("bb0_ignt", 32'(instr_bus.gnt), 32'h1);
    chk("bb0_maddr", mem_bus.addr, 32'h8000_0000);
    push(1'b0, 32'h1111_0000);
    nxt();
    instr_bus.addr = 32'h8000_0004; mem_bus.rvalid = 1; mem_bus.rdata = 32'h1111_0000;
    @(negedge clk);
    $display("fetch addr=80000004");
    chk("bb1_busy", 32'(busy), 32'h1);
    chk("bb1_ignt", 32'(instr_bus.gnt), 32'h1);
    chk("bb1_maddr", mem_bus.addr, 32'h8000_0004);
    rsp_check("bb1");
    push(1'b0, 32'h1111_0004);
    nxt();
    instr_bus.req = 0; mem_bus.gnt = 0; mem_bus.rdata = 32'h1111_0004;
    @(negedge clk);
    chk("bb2_busy", 32'(busy), 32'h1);
    chk("bb2_mreq", 32'(mem_bus.req), 32'h0);
    rsp_check("bb2");
    nxt();
    mem_bus.rvalid = 0;
    @(negedge clk);
    chk("bb3_busy", 32'(busy), 32'h0);

    // Memory stall on an instruction-channel write.
    for (int k = 0; k < 4; k++) begin
      nxt();
      instr_bus.req = 1; instr_bus.addr = 32'h8000_0040; instr_bus.we = 1;
      instr_bus.wdata = 32'hCAFE_0001; instr_bus.strb = 4'hC; mem_bus.gnt = (k == 3);
      @(negedge clk);
      $display("stall cycle %0d mem_gnt=%0d", k, k == 3);
      chk($sformatf("st%0d_mreq", k), 32'(mem_bus.req), 32'h1);
      chk($sformatf("st%0d_ignt", k), 32'(instr_bus.gnt), 32'(k == 3));
      chk($sformatf("st%0d_maddr", k), mem_bus.addr, 32'h8000_0040);
      chk($sformatf("st%0d_mwe", k), {mem_bus.wdata[31:5], mem_bus.strb, mem_bus.we},
          {27'(32'hCAFE_0001 >> 5), 4'hC, 1'b1});
    end
    push(1'b0, 32'h5555_AAAA);
    nxt();
    instr_bus.req = 0; instr_bus.we = 0; instr_bus.strb = 0; mem_bus.gnt = 0;
    @(negedge clk);
    chk("st4_busy", 32'(busy), 32'h1);
    no_rsp("st4");
    nxt();
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h5555_AAAA;
    @(negedge clk);
    rsp_check("st5");
    nxt();
    mem_bus.rvalid = 0;

    // Reset while a data response is pending.
    nxt();
    data_bus.req = 1; data_bus.addr = 32'h8000_0200; mem_bus.gnt = 1;
    @(negedge clk);
    $display("data req addr=80000200 then reset");
    chk("rw_dgnt", 32'(data_bus.gnt), 32'h1);
    nxt();
    data_bus.req = 0; mem_bus.gnt = 0; rst = 1;
    @(negedge clk);
    chk("rw_busy", 32'(busy), 32'h1);
    nxt();
    rst = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    no_rsp("rw_drop");
    chk("rw_busy0", 32'(busy), 32'h0);
    chk("rw_state", 32'(dut.state_q), 32'(IDLE));
    nxt();
    mem_bus.rvalid = 0; data_bus.req = 1; data_bus.addr = 32'h8000_0300; mem_bus.gnt = 1;
    @(negedge clk);
    chk("rw_dgnt2", 32'(data_bus.gnt), 32'h1);
    chk("rw_maddr2", mem_bus.addr, 32'h8000_0300);
    push(1'b1, 32'h0BAD_F00D);
    nxt();
    data_bus.req = 0; mem_bus.gnt = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'h0BAD_F00D;
    @(negedge clk);
    rsp_check("rw_rsp");
    nxt();
    mem_bus.rvalid = 0;

    // Stray response while idle.
    nxt();
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h1234_5678;
    @(negedge clk);
    $display("stray rvalid rdata=12345678");
    no_rsp("stray");
    chk("stray_busy", 32'(busy), 32'h0);
    nxt();
    mem_bus.rvalid = 0;
    @(negedge clk);
    chk("stray_state", 32'(dut.state_q), 32'(IDLE));
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
